// File: rtl/axi4lite_pkg.sv
// Shared AXI4-Lite types and helpers for the register-file slave and its write controller.
// Latency: none (types, constants and pure functions only).
// Backpressure: not applicable.
package axi4lite_pkg;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_SLVERR = 2'b10
    } resp_t;

    // Strobe width for a given data width; usable in parameter context.
    function automatic int unsigned strb_w(input int unsigned data_w);
        return data_w / 8;
    endfunction

    // Register index from a byte address; lsb = log2(bytes per register).
    // Address widths up to 64 bits are supported.
    function automatic logic [63:0] addr_to_idx(input logic [63:0] addr, input int unsigned lsb);
        return addr >> lsb;
    endfunction

endpackage

// File: rtl/axi4lite_wr_ctrl.sv
// AW/W 1-deep buffering, write-commit generation and B channel for the register-file slave.
// Latency: commit fires in the cycle both AW and W are held or handshaking; B_VALID rises on that edge.
// Backpressure: AW/W readies drop while a buffer is full or B is pending; B holds until b_rdy.
// Ports: aw_*/w_*/b_* bus channels; accept_en gates readies; cmt_* present the write to the bank,
//        cmt_err (decoded by the top) selects SLVERR.
module axi4lite_wr_ctrl
    import axi4lite_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int STRB_W = strb_w(DATA_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              accept_en,
    input  logic              aw_vld,
    output logic              aw_rdy,
    input  logic [ADDR_W-1:0] aw_addr,
    input  logic              w_vld,
    output logic              w_rdy,
    input  logic [DATA_W-1:0] w_data,
    input  logic [STRB_W-1:0] w_strb,
    output logic              b_vld,
    input  logic              b_rdy,
    output logic [1:0]        b_resp,
    output logic              commit,
    output logic [ADDR_W-1:0] cmt_addr,
    output logic [DATA_W-1:0] cmt_data,
    output logic [STRB_W-1:0] cmt_strb,
    input  logic              cmt_err
);

    logic              aw_full_q, aw_full_d;
    logic [ADDR_W-1:0] aw_addr_q, aw_addr_d;
    logic              w_full_q, w_full_d;
    logic [DATA_W-1:0] w_data_q, w_data_d;
    logic [STRB_W-1:0] w_strb_q, w_strb_d;
    logic              b_vld_q, b_vld_d;
    resp_t             b_resp_q, b_resp_d;
    logic              aw_hs, w_hs;

    assign aw_rdy = accept_en && !aw_full_q && !b_vld_q;
    assign w_rdy  = accept_en && !w_full_q && !b_vld_q;
    assign aw_hs  = aw_vld && aw_rdy;
    assign w_hs   = w_vld && w_rdy;

    // A handshake this cycle counts as "full" so AW+W in cycle N commits at the end of N.
    assign commit   = (aw_full_q || aw_hs) && (w_full_q || w_hs);
    assign cmt_addr = aw_full_q ? aw_addr_q : aw_addr;
    assign cmt_data = w_full_q ? w_data_q : w_data;
    assign cmt_strb = w_full_q ? w_strb_q : w_strb;

    assign b_vld  = b_vld_q;
    assign b_resp = b_resp_q;

    always_comb begin
        aw_full_d = aw_full_q;
        aw_addr_d = aw_addr_q;
        w_full_d  = w_full_q;
        w_data_d  = w_data_q;
        w_strb_d  = w_strb_q;
        b_vld_d   = b_vld_q;
        b_resp_d  = b_resp_q;
        if (aw_hs) begin
            aw_full_d = 1'b1;
            aw_addr_d = aw_addr;
        end
        if (w_hs) begin
            w_full_d = 1'b1;
            w_data_d = w_data;
            w_strb_d = w_strb;
        end
        // Commit and a pending B are mutually exclusive: readies are low while B is pending.
        if (commit) begin
            aw_full_d = 1'b0;
            w_full_d  = 1'b0;
            b_vld_d   = 1'b1;
            b_resp_d  = cmt_err ? RESP_SLVERR : RESP_OKAY;
        end else if (b_vld_q && b_rdy) begin
            b_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            aw_full_q <= 1'b0;
            aw_addr_q <= '0;
            w_full_q  <= 1'b0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            b_vld_q   <= 1'b0;
            b_resp_q  <= RESP_OKAY;
        end else begin
            aw_full_q <= aw_full_d;
            aw_addr_q <= aw_addr_d;
            w_full_q  <= w_full_d;
            w_data_q  <= w_data_d;
            w_strb_q  <= w_strb_d;
            b_vld_q   <= b_vld_d;
            b_resp_q  <= b_resp_d;
        end
    end

endmodule

// File: rtl/axi4lite_regfile_slave.sv
// AXI4-Lite slave terminating the bus in NUM_REGS registers with byte strobes, RO mask and SLVERR.
// Latency: write commit and read data both one cycle after the completing handshake.
// Backpressure: one outstanding write and one outstanding read; readies low until B/R accepted.
// Ports: A_CLK/A_RST (sync, active-high), AW/W/B/AR/R AXI4-Lite channels, regs_q flattened register
//        contents, wr_pulse one-cycle per-register write strobe. DATA_W must be 32 or 64.
module axi4lite_regfile_slave
    import axi4lite_pkg::*;
#(
    parameter int                          ADDR_W   = 32,
    parameter int                          DATA_W   = 32,
    parameter int                          NUM_REGS = 16,
    parameter logic [NUM_REGS-1:0]         RO_MASK  = '0,
    parameter logic [NUM_REGS*DATA_W-1:0]  RST_VAL  = '0
) (
    input  logic                         A_CLK,
    input  logic                         A_RST,
    input  logic                         AW_VALID,
    output logic                         AW_READY,
    input  logic [ADDR_W-1:0]            AW_ADDR,
    input  logic                         W_VALID,
    output logic                         W_READY,
    input  logic [DATA_W-1:0]            W_DATA,
    input  logic [DATA_W/8-1:0]          W_STRB,
    output logic                         B_VALID,
    input  logic                         B_READY,
    output logic [1:0]                   B_RESP,
    input  logic                         AR_VALID,
    output logic                         AR_READY,
    input  logic [ADDR_W-1:0]            AR_ADDR,
    output logic                         R_VALID,
    input  logic                         R_READY,
    output logic [DATA_W-1:0]            R_DATA,
    output logic [1:0]                   R_RESP,
    output logic [NUM_REGS*DATA_W-1:0]   regs_q,
    output logic [NUM_REGS-1:0]          wr_pulse
);

    localparam int STRB_W = strb_w(DATA_W);
    localparam int LSB    = $clog2(STRB_W);

    logic                       rdy_en_q, rdy_en_d;
    logic                       accept_en;
    logic [NUM_REGS*DATA_W-1:0] regs_d;
    logic [NUM_REGS-1:0]        wr_pulse_q, wr_pulse_d;
    logic                       r_vld_q, r_vld_d;
    logic [DATA_W-1:0]          r_data_q, r_data_d;
    resp_t                      r_resp_q, r_resp_d;

    logic                       commit;
    logic [ADDR_W-1:0]          cmt_addr;
    logic [DATA_W-1:0]          cmt_data;
    logic [STRB_W-1:0]          cmt_strb;
    logic                       cmt_err;
    logic [63:0]                wr_idx, rd_idx;
    logic                       ar_hs;

    // Readies come up only in the first cycle after reset has been released.
    assign rdy_en_d  = 1'b1;
    assign accept_en = rdy_en_q && !A_RST;

    axi4lite_wr_ctrl #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .STRB_W (STRB_W)
    ) u_wr_ctrl (
        .clk       (A_CLK),
        .rst       (A_RST),
        .accept_en (accept_en),
        .aw_vld    (AW_VALID),
        .aw_rdy    (AW_READY),
        .aw_addr   (AW_ADDR),
        .w_vld     (W_VALID),
        .w_rdy     (W_READY),
        .w_data    (W_DATA),
        .w_strb    (W_STRB),
        .b_vld     (B_VALID),
        .b_rdy     (B_READY),
        .b_resp    (B_RESP),
        .commit    (commit),
        .cmt_addr  (cmt_addr),
        .cmt_data  (cmt_data),
        .cmt_strb  (cmt_strb),
        .cmt_err   (cmt_err)
    );

    assign wr_idx = addr_to_idx(64'(cmt_addr), LSB);
    assign rd_idx = addr_to_idx(64'(AR_ADDR), LSB);

    // Out-of-range or read-only targets get SLVERR and leave the bank untouched.
    always_comb begin
        cmt_err = (wr_idx >= 64'(NUM_REGS));
        for (int i = 0; i < NUM_REGS; i++) begin
            if (wr_idx == 64'(i) && RO_MASK[i]) begin
                cmt_err = 1'b1;
            end
        end
    end

    always_comb begin
        regs_d     = regs_q;
        wr_pulse_d = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (commit && !cmt_err && wr_idx == 64'(i) && (|cmt_strb)) begin
                wr_pulse_d[i] = 1'b1;
                for (int b = 0; b < STRB_W; b++) begin
                    if (cmt_strb[b]) begin
                        regs_d[i*DATA_W + b*8 +: 8] = cmt_data[b*8 +: 8];
                    end
                end
            end
        end
    end

    // Read path samples regs_q, so a same-cycle write commit is not visible to this read.
    assign AR_READY = accept_en && !r_vld_q;
    assign ar_hs    = AR_VALID && AR_READY;

    always_comb begin
        r_vld_d  = r_vld_q;
        r_data_d = r_data_q;
        r_resp_d = r_resp_q;
        if (ar_hs) begin
            r_vld_d  = 1'b1;
            r_data_d = '0;
            r_resp_d = RESP_SLVERR;
            for (int i = 0; i < NUM_REGS; i++) begin
                if (rd_idx == 64'(i)) begin
                    r_data_d = regs_q[i*DATA_W +: DATA_W];
                    r_resp_d = RESP_OKAY;
                end
            end
        end else if (r_vld_q && R_READY) begin
            r_vld_d = 1'b0;
        end
    end

    always_ff @(posedge A_CLK) begin
        if (A_RST) begin
            rdy_en_q   <= 1'b0;
            regs_q     <= RST_VAL;
            wr_pulse_q <= '0;
            r_vld_q    <= 1'b0;
            r_data_q   <= '0;
            r_resp_q   <= RESP_OKAY;
        end else begin
            rdy_en_q   <= rdy_en_d;
            regs_q     <= regs_d;
            wr_pulse_q <= wr_pulse_d;
            r_vld_q    <= r_vld_d;
            r_data_q   <= r_data_d;
            r_resp_q   <= r_resp_d;
        end
    end

    assign wr_pulse = wr_pulse_q;
    assign R_VALID  = r_vld_q;
    assign R_DATA   = r_data_q;
    assign R_RESP   = r_resp_q;

endmodule

// File: tb/tb_axi4lite_regfile_slave.sv
// Directed bench for axi4lite_regfile_slave (16 x 32-bit, register 15 read-only, zero reset values).
// Latency: checks one-cycle write commit and one-cycle read data after each handshake.
// Backpressure: holds B_READY/R_READY low to check stability and ready gating.
module tb_axi4lite_regfile_slave;

    logic         A_CLK = 1'b0;
    logic         A_RST;
    logic         AW_VALID, AW_READY;
    logic [31:0]  AW_ADDR;
    logic         W_VALID, W_READY;
    logic [31:0]  W_DATA;
    logic [3:0]   W_STRB;
    logic         B_VALID, B_READY;
    logic [1:0]   B_RESP;
    logic         AR_VALID, AR_READY;
    logic [31:0]  AR_ADDR;
    logic         R_VALID, R_READY;
    logic [31:0]  R_DATA;
    logic [1:0]   R_RESP;
    logic [511:0] regs_q;
    logic [15:0]  wr_pulse;

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    axi4lite_regfile_slave #(
        .ADDR_W   (32),
        .DATA_W   (32),
        .NUM_REGS (16),
        .RO_MASK  (16'h8000),
        .RST_VAL  ('0)
    ) dut (
        .A_CLK    (A_CLK),
        .A_RST    (A_RST),
        .AW_VALID (AW_VALID),
        .AW_READY (AW_READY),
        .AW_ADDR  (AW_ADDR),
        .W_VALID  (W_VALID),
        .W_READY  (W_READY),
        .W_DATA   (W_DATA),
        .W_STRB   (W_STRB),
        .B_VALID  (B_VALID),
        .B_READY  (B_READY),
        .B_RESP   (B_RESP),
        .AR_VALID (AR_VALID),
        .AR_READY (AR_READY),
        .AR_ADDR  (AR_ADDR),
        .R_VALID  (R_VALID),
        .R_READY  (R_READY),
        .R_DATA   (R_DATA),
        .R_RESP   (R_RESP),
        .regs_q   (regs_q),
        .wr_pulse (wr_pulse)
    );

    always #5 A_CLK = ~A_CLK;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // mode 0: AW and W together, 1: AW one cycle before W, 2: W one cycle before AW.
    // Returns #1 after the edge of the completing handshake.
    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input int mode);
        bit aw_done, w_done, aw_hs, w_hs;
        int n;
        aw_done = 0;
        w_done  = 0;
        n       = 0;
        AW_ADDR = addr;
        W_DATA  = data;
        W_STRB  = strb;
        while (!(aw_done && w_done) && n < 20) begin
            AW_VALID = !aw_done && !(mode == 2 && !w_done);
            W_VALID  = !w_done && !(mode == 1 && !aw_done);
            @(negedge A_CLK);
            aw_hs = AW_VALID && AW_READY;
            w_hs  = W_VALID && W_READY;
            @(posedge A_CLK);
            #1;
            aw_done = aw_done || aw_hs;
            w_done  = w_done || w_hs;
            n++;
        end
        AW_VALID = 1'b0;
        W_VALID  = 1'b0;
        if (!(aw_done && w_done)) chk("wr_handshake_timeout", 64'(aw_done && w_done), 64'd1);
    endtask

    task automatic axi_bresp(input string tag, input logic [1:0] exp_resp);
        chk({tag, "_bvld"}, 64'(B_VALID), 64'd1);
        chk({tag, "_bresp"}, 64'(B_RESP), 64'(exp_resp));
        B_READY = 1'b1;
        @(posedge A_CLK);
        #1;
        B_READY = 1'b0;
        chk({tag, "_bdrop"}, 64'(B_VALID), 64'd0);
    endtask

    task automatic axi_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp);
        bit hs;
        int n;
        hs       = 0;
        n        = 0;
        AR_ADDR  = addr;
        AR_VALID = 1'b1;
        while (!hs && n < 20) begin
            @(negedge A_CLK);
            hs = AR_READY;
            @(posedge A_CLK);
            #1;
            n++;
        end
        AR_VALID = 1'b0;
        if (!hs) chk("rd_handshake_timeout", 64'(hs), 64'd1);
        chk("rd_latency_rvld", 64'(R_VALID), 64'd1);
        data    = R_DATA;
        resp    = R_RESP;
        R_READY = 1'b1;
        @(posedge A_CLK);
        #1;
        R_READY = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic [1:0]  rr;

        A_RST    = 1'b1;
        AW_VALID = 1'b0;
        AW_ADDR  = '0;
        W_VALID  = 1'b0;
        W_DATA   = '0;
        W_STRB   = '0;
        B_READY  = 1'b0;
        AR_VALID = 1'b0;
        AR_ADDR  = '0;
        R_READY  = 1'b0;

        // Reset state
        repeat (3) @(posedge A_CLK);
        #1;
        chk("rst_aw_rdy", 64'(AW_READY), 64'd0);
        chk("rst_w_rdy", 64'(W_READY), 64'd0);
        chk("rst_ar_rdy", 64'(AR_READY), 64'd0);
        chk("rst_bvld", 64'(B_VALID), 64'd0);
        chk("rst_rvld", 64'(R_VALID), 64'd0);
        chk("rst_rdata", 64'(R_DATA), 64'd0);
        chk("rst_pulse", 64'(wr_pulse), 64'd0);
        chk("rst_regs", 64'(|regs_q), 64'd0);
        A_RST = 1'b0;
        chk("rel_ar_rdy_low", 64'(AR_READY), 64'd0);
        @(posedge A_CLK);
        #1;
        chk("rel_ar_rdy", 64'(AR_READY), 64'd1);
        chk("rel_aw_rdy", 64'(AW_READY), 64'd1);
        chk("rel_w_rdy", 64'(W_READY), 64'd1);

        axi_read(32'h04, rd, rr);
        chk("rd04_init_data", 64'(rd), 64'd0);
        chk("rd04_init_resp", 64'(rr), 64'(OKAY));

        // Full-word write, AW before W
        axi_write(32'h04, 32'h1234_5678, 4'hF, 1);
        chk("wr04_pulse", 64'(wr_pulse), 64'h0002);
        chk("wr04_regs", 64'(regs_q[63:32]), 64'h1234_5678);
        axi_bresp("wr04", OKAY);
        chk("wr04_pulse_clr", 64'(wr_pulse), 64'd0);
        axi_read(32'h04, rd, rr);
        chk("rd04_data", 64'(rd), 64'h1234_5678);
        chk("rd04_resp", 64'(rr), 64'(OKAY));

        // Byte-lane merge: lanes 0 and 2 from the second write
        axi_write(32'h08, 32'hAABB_CCDD, 4'hF, 0);
        axi_bresp("wr08a", OKAY);
        axi_write(32'h08, 32'h1122_3344, 4'b0101, 2);
        chk("wr08b_pulse", 64'(wr_pulse), 64'h0004);
        axi_bresp("wr08b", OKAY);
        axi_read(32'h08, rd, rr);
        chk("rd08_merge", 64'(rd), 64'hAA22_CC44);

        // Read-only and out-of-range targets
        axi_write(32'h3C, 32'hFFFF_FFFF, 4'hF, 0);
        chk("wr3c_pulse", 64'(wr_pulse), 64'd0);
        axi_bresp("wr3c", SLVERR);
        chk("wr3c_regs", 64'(regs_q[511:480]), 64'd0);
        axi_write(32'h40, 32'hFFFF_FFFF, 4'hF, 1);
        chk("wr40_pulse", 64'(wr_pulse), 64'd0);
        axi_bresp("wr40", SLVERR);
        axi_read(32'h40, rd, rr);
        chk("rd40_data", 64'(rd), 64'd0);
        chk("rd40_resp", 64'(rr), 64'(SLVERR));
        axi_read(32'h3C, rd, rr);
        chk("rd3c_data", 64'(rd), 64'd0);
        chk("rd3c_resp", 64'(rr), 64'(OKAY));

        // Zero strobe: OKAY, nothing changes
        axi_write(32'h04, 32'hFFFF_FFFF, 4'h0, 0);
        chk("wrs0_pulse", 64'(wr_pulse), 64'd0);
        chk("wrs0_regs", 64'(regs_q[63:32]), 64'h1234_5678);
        axi_bresp("wrs0", OKAY);

        // B backpressure
        axi_write(32'h0C, 32'h0000_0055, 4'hF, 0);
        for (int i = 0; i < 5; i++) begin
            chk("bp_bvld", 64'(B_VALID), 64'd1);
            chk("bp_bresp", 64'(B_RESP), 64'(OKAY));
            chk("bp_rdys", 64'({AW_READY, W_READY}), 64'd0);
            @(posedge A_CLK);
            #1;
        end
        axi_bresp("bp", OKAY);

        // R backpressure
        AR_ADDR  = 32'h0C;
        AR_VALID = 1'b1;
        @(posedge A_CLK);
        #1;
        AR_VALID = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("rbp_rvld", 64'(R_VALID), 64'd1);
            chk("rbp_rdata", 64'(R_DATA), 64'h55);
            chk("rbp_ar_rdy", 64'(AR_READY), 64'd0);
            @(posedge A_CLK);
            #1;
        end
        R_READY = 1'b1;
        @(posedge A_CLK);
        #1;
        R_READY = 1'b0;
        chk("rbp_rdrop", 64'(R_VALID), 64'd0);

        // Same-cycle read and write commit to 0x10: read sees the old value
        AW_ADDR  = 32'h10;
        W_DATA   = 32'hDEAD_BEEF;
        W_STRB   = 4'hF;
        AR_ADDR  = 32'h10;
        AW_VALID = 1'b1;
        W_VALID  = 1'b1;
        AR_VALID = 1'b1;
        @(negedge A_CLK);
        chk("same_rdys", 64'({AW_READY, W_READY, AR_READY}), 64'd7);
        @(posedge A_CLK);
        #1;
        AW_VALID = 1'b0;
        W_VALID  = 1'b0;
        AR_VALID = 1'b0;
        chk("same_rvld", 64'(R_VALID), 64'd1);
        chk("same_rdata_old", 64'(R_DATA), 64'd0);
        chk("same_bvld", 64'(B_VALID), 64'd1);
        chk("same_regs", 64'(regs_q[159:128]), 64'hDEAD_BEEF);
        chk("same_pulse", 64'(wr_pulse), 64'h0010);
        R_READY = 1'b1;
        B_READY = 1'b1;
        @(posedge A_CLK);
        #1;
        R_READY = 1'b0;
        B_READY = 1'b0;
        axi_read(32'h10, rd, rr);
        chk("rd10_new", 64'(rd), 64'hDEAD_BEEF);

        // Reset with a write response pending
        axi_write(32'h14, 32'h0000_0077, 4'hF, 0);
        chk("rstp_bvld_before", 64'(B_VALID), 64'd1);
        A_RST = 1'b1;
        @(posedge A_CLK);
        #1;
        chk("rstp_bvld", 64'(B_VALID), 64'd0);
        chk("rstp_regs", 64'(|regs_q), 64'd0);
        chk("rstp_aw_rdy", 64'(AW_READY), 64'd0);
        A_RST = 1'b0;
        @(posedge A_CLK);
        #1;
        chk("rstp_no_resp", 64'(B_VALID), 64'd0);
        axi_read(32'h04, rd, rr);
        chk("rstp_rd04", 64'(rd), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/axi4lite_regfile_slave.md
Name: axi4lite_regfile_slave

Overview:
Parametrised AXI4-Lite slave that terminates the bus in a bank of NUM_REGS memory-mapped registers. It is the successor to the fixed-width axi4lite_slave. New capabilities: configurable data/address width and register count, WSTRB byte-lane writes, independent AW/W acceptance, per-register read-only mask, and SLVERR responses. Sits behind the VIP/interconnect master and exposes all register contents to fabric logic.

Parameters:
ADDR_W, 32, AW_ADDR/AR_ADDR width
DATA_W, 32, data width; must be 32 or 64
NUM_REGS, 16, number of registers; >=2, need not be a power of two
RO_MASK, {NUM_REGS{1'b0}}, bit i=1 makes register i read-only from the bus
RST_VAL, '0, NUM_REGS*DATA_W packed reset values; register i = RST_VAL[i*DATA_W +: DATA_W]

Ports:
A_CLK  in  1  clock; all logic on rising edge
A_RST  in  1  synchronous, active-high reset
AW_VALID in 1 / AW_READY out 1 / AW_ADDR in ADDR_W  write address channel
W_VALID in 1 / W_READY out 1 / W_DATA in DATA_W / W_STRB in DATA_W/8  write data channel
B_VALID out 1 / B_READY in 1 / B_RESP out 2  write response channel
AR_VALID in 1 / AR_READY out 1 / AR_ADDR in ADDR_W  read address channel
R_VALID out 1 / R_READY in 1 / R_DATA out DATA_W / R_RESP out 2  read data channel
regs_q  out  NUM_REGS*DATA_W  current register contents, flattened
wr_pulse  out  NUM_REGS  1-cycle strobe, bit i set in the cycle after register i is written

Behaviour:
- Reset: clock and reset are one clock, synchronous, active-high. While A_RST=1, at each edge:
  - all READY, B_VALID and R_VALID are driven 0; B_RESP=0, R_RESP=0, R_DATA=0;
  - wr_pulse=0 and registers load RST_VAL;
  - buffered AW/W/AR state is discarded. Reset mid-transaction drops the transaction with no response.
  - READYs rise in the first cycle after A_RST falls.
- Decode:
  - LSB = log2(DATA_W/8); byte-offset bits below LSB are ignored.
  - idx = ADDR >> LSB. idx >= NUM_REGS is out of range.
- Write path:
  - AW and W are accepted independently, in either order, and each is held in a 1-deep buffer.
  - AW_READY = !aw_full && !B_VALID; W_READY = !w_full && !B_VALID.
  - When both buffers are full (including same-cycle handshakes), the commit occurs on the next edge:
    - byte lanes with W_STRB=1 are updated;
    - B_VALID=1 is asserted;
    - both buffers clear.
  - Latency: AW+W handshakes in cycle N -> register updated and B_VALID high in cycle N+1.
  - B_RESP: OKAY=2'b00. SLVERR=2'b10 if idx is out of range or RO_MASK[idx]=1; on SLVERR no register changes and no wr_pulse.
  - W_STRB=0: OKAY, no change, no wr_pulse.
  - B_VALID holds until B_READY=1, then drops at that edge. The next AW/W may be accepted in the cycle after.
- Read path:
  - AR_READY = !R_VALID.
  - AR handshake in cycle N -> R_VALID=1 with R_DATA/R_RESP stable in cycle N+1, held until R_READY; one outstanding read.
  - Out-of-range read: R_DATA=0, R_RESP=SLVERR. Reads of RO registers return OKAY.
- Simultaneous events:
  - A read and a write commit to the same register in the same cycle: the read returns the pre-write value.
  - Read and write channels are fully independent; there is no ordering between them.
- Outputs: regs_q is registered and reflects a write in the same cycle B_VALID rises.
- Fabric logic cannot write registers in this generation; RO registers hold RST_VAL.

Decomposition:
- Shared package axi4lite_pkg holds:
  - resp_t enum (RESP_OKAY=2'b00, RESP_SLVERR=2'b10);
  - the function addr_to_idx(addr, lsb);
  - a localparam helper for strobe width.
- One natural sub-module: axi4lite_wr_ctrl, covering the AW/W buffering, commit generation and B channel. Decode, register bank and read path stay in the top.

Test Plan (NUM_REGS=16, DATA_W=32, RO_MASK=16'h8000, RST_VAL=0):
- Reset then read 0x04 -> AR_READY=1 one cycle after reset release; R_DATA=0, R_RESP=OKAY one cycle after the AR handshake.
- Write 0x04 with data 0x1234_5678 and strobe 4'hF, AW one cycle before W -> B_RESP=OKAY, wr_pulse[1] for one cycle, read 0x04 returns 0x1234_5678.
- Write 0x08 with 0xAABB_CCDD and strobe 4'hF, then write 0x08 with 0x1122_3344 and strobe 4'b0101 -> read returns 0xAA22_CC44.
- Write to 0x3C (RO) and to 0x40 (out of range) -> both B_RESP=SLVERR, no wr_pulse; read 0x40 gives R_DATA=0, R_RESP=SLVERR; read 0x3C gives R_RESP=OKAY, R_DATA=0.
- Backpressure: hold B_READY=0 for 5 cycles -> B_VALID stays high with B_RESP stable, AW_READY=W_READY=0 throughout. Likewise hold R_READY=0 -> R_DATA stable and AR_READY=0.
- Same-cycle read and write commit to 0x10 (old value 0, new value 0xDEAD_BEEF) -> read returns 0, a following read returns 0xDEAD_BEEF. Asserting A_RST with B_VALID pending -> B_VALID=0 on the next edge and all registers return to 0.
